// File: rtl/present_pkg.sv
// ---------------------------------------------------------------------------
// present_pkg
// Shared definitions for the PRESENT-80 iterative cipher core:
//   - block/key/round-counter widths and the default round count
//   - FSM state encoding
//   - pLayer bit permutation helper
// ---------------------------------------------------------------------------
package present_pkg;

    localparam int BLOCK_W        = 64;
    localparam int KEY_W          = 80;
    localparam int ROUNDS_DEFAULT = 31;
    localparam int ROUND_W        = 5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Bit i moves to (16*i) mod 63 for i = 0..62; the MSB is a fixed point.
    function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] din);
        logic [BLOCK_W-1:0] dout;
        dout = 64'd0;
        for (int i = 0; i < 63; i++) begin
            dout[(16 * i) % 63] = din[i];
        end
        dout[63] = din[63];
        return dout;
    endfunction

endpackage

// File: rtl/present_cipher_core_sbox.sv
// ---------------------------------------------------------------------------
// SBox
// The 4-bit PRESENT substitution box, purely combinational.
// Ports:
//   orig        : 4-bit input nibble
//   substituted : 4-bit substituted nibble
// ---------------------------------------------------------------------------
module SBox (
    input  logic [3:0] orig,
    output logic [3:0] substituted
);

    // PRESENT S-box lookup table.
    always_comb begin
        substituted = 4'h0;
        case (orig)
            4'h0:    substituted = 4'hC;
            4'h1:    substituted = 4'h5;
            4'h2:    substituted = 4'h6;
            4'h3:    substituted = 4'hB;
            4'h4:    substituted = 4'h9;
            4'h5:    substituted = 4'h0;
            4'h6:    substituted = 4'hA;
            4'h7:    substituted = 4'hD;
            4'h8:    substituted = 4'h3;
            4'h9:    substituted = 4'hE;
            4'hA:    substituted = 4'hF;
            4'hB:    substituted = 4'h8;
            4'hC:    substituted = 4'h4;
            4'hD:    substituted = 4'h7;
            4'hE:    substituted = 4'h1;
            4'hF:    substituted = 4'h2;
            default: substituted = 4'h0;
        endcase
    end

endmodule

// File: rtl/present_cipher_core.sv
// ---------------------------------------------------------------------------
// present_cipher_core
// Iterative PRESENT-80 encryption core, one round per clock.
// Parameter:
//   ROUNDS     : full rounds before the final key whitening (default 31)
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset
//   start      : encrypt request, accepted only while idle
//   plaintext  : 64-bit input block, sampled on an accepted start
//   key        : 80-bit key, sampled on an accepted start
//   busy       : high while rounds are in progress
//   done       : one-cycle pulse when ciphertext becomes valid
//   ciphertext : result, held until the next completed operation
// ---------------------------------------------------------------------------
module present_cipher_core
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [BLOCK_W-1:0] plaintext,
    input  logic [KEY_W-1:0]   key,
    output logic               busy,
    output logic               done,
    output logic [BLOCK_W-1:0] ciphertext
);

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_accept;
    logic                 w_last;

    logic [BLOCK_W-1:0]   r_data;
    logic [KEY_W-1:0]     r_key;
    logic [ROUND_W-1:0]   r_round;
    logic                 r_busy;
    logic                 r_done;
    logic [BLOCK_W-1:0]   r_ciphertext;

    logic [BLOCK_W-1:0]   w_addkey;
    logic [BLOCK_W-1:0]   w_sbox_out;
    logic [BLOCK_W-1:0]   w_round_out;
    logic [KEY_W-1:0]     w_key_rot;
    logic [3:0]           w_key_sbox;
    logic [KEY_W-1:0]     w_key_next;

    // ---------------- round datapath ----------------
    assign w_addkey = r_data ^ r_key[79:16];

    for (genvar g = 0; g < 16; g++) begin : g_sbox
        SBox u_sbox (
            .orig        (w_addkey[4*g+3:4*g]),
            .substituted (w_sbox_out[4*g+3:4*g])
        );
    end

    assign w_round_out = p_layer(w_sbox_out);

    // ---------------- key schedule ----------------
    // Rotate left by 61, substitute the top nibble, then fold in the
    // counter value of the round being executed.
    assign w_key_rot = {r_key[18:0], r_key[79:19]};

    SBox u_sbox_key (
        .orig        (w_key_rot[79:76]),
        .substituted (w_key_sbox)
    );

    assign w_key_next = {w_key_sbox,
                         w_key_rot[75:20],
                         w_key_rot[19:15] ^ r_round,
                         w_key_rot[14:0]};

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and per-cycle control decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_round == ROUND_W'(ROUNDS)) begin
                    w_last       = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Cipher state, key register, round counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= 64'd0;
            r_key        <= 80'd0;
            r_round      <= 5'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ciphertext <= 64'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_data  <= plaintext;
                r_key   <= key;
                r_round <= 5'd1;
                r_busy  <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_data  <= w_round_out;
                r_key   <= w_key_next;
                r_round <= r_round + 5'd1;
                if (w_last) begin
                    // Final whitening uses the key produced in this same cycle.
                    r_ciphertext <= w_round_out ^ w_key_next[79:16];
                    r_done       <= 1'b1;
                    r_busy       <= 1'b0;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ciphertext = r_ciphertext;

endmodule

// File: tb/tb_present_cipher_core.sv
// ---------------------------------------------------------------------------
// tb_present_cipher_core
// Directed bench for present_cipher_core using published PRESENT-80 vectors.
// Inputs are driven and outputs sampled on the falling clock edge.
// "Cycle n" below means the n-th cycle after the edge that accepted start,
// with the cycle following that edge counted as cycle 1.
// ---------------------------------------------------------------------------
module tb_present_cipher_core;

    logic        clk;
    logic        reset;
    logic        start;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        busy;
    logic        done;
    logic [63:0] ciphertext;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] CT_00 = 64'h5579C1387B228445;
    localparam logic [63:0] CT_0F = 64'hE72C46C0F5945049;
    localparam logic [63:0] CT_F0 = 64'hA112FFC72F68417B;
    localparam logic [63:0] CT_FF = 64'h3333DCD3213210D2;
    localparam logic [63:0] ALL1_64 = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [79:0] ALL1_80 = 80'hFFFFFFFFFFFFFFFFFFFF;

    present_cipher_core #(.ROUNDS(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start one operation from idle, scramble the inputs while it runs, then
    // verify the full latency profile, result and single-cycle done pulse.
    task automatic run_op(input string tag, input logic [63:0] pt,
                          input logic [79:0] k, input logic [63:0] exp);
        int early_done;
        early_done = 0;
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        plaintext = ~pt;
        key       = ~k;
        check({tag, "_busy_c1"}, {63'd0, busy}, 64'd1);
        for (int n = 2; n <= 32; n++) begin
            @(negedge clk);
            if (n < 32 && done) early_done++;
        end
        check({tag, "_early_done"}, 64'(early_done), 64'd0);
        check({tag, "_done_c32"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_c32"}, {63'd0, busy}, 64'd0);
        check({tag, "_ct"}, ciphertext, exp);
        @(negedge clk);
        check({tag, "_done_c33"}, {63'd0, done}, 64'd0);
        check({tag, "_ct_hold"}, ciphertext, exp);
    endtask

    initial begin
        int ndone;
        int ct_changed;

        reset     = 1'b1;
        start     = 1'b0;
        plaintext = 64'd0;
        key       = 80'd0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_ct", ciphertext, 64'd0);

        // First start on the first edge after reset deasserts.
        reset = 1'b0;
        run_op("v00", 64'd0, 80'd0, CT_00);
        run_op("v0F", 64'd0, ALL1_80, CT_0F);
        run_op("vF0", ALL1_64, 80'd0, CT_F0);
        run_op("vFF", ALL1_64, ALL1_80, CT_FF);

        // Start and new operands during RUN are ignored.
        plaintext = 64'd0;
        key       = 80'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int n = 2; n <= 32; n++) begin
            @(negedge clk);
            if (n == 10) begin
                start     = 1'b1;
                plaintext = ALL1_64;
                key       = ALL1_80;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        check("ign_ct", ciphertext, CT_00);
        check("ign_done_c32", {63'd0, done}, 64'd1);
        for (int n = 33; n <= 72; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ign_done_count", 64'(ndone), 64'd1);
        check("ign_busy_after", {63'd0, busy}, 64'd0);

        // Reset mid-run aborts without a done pulse.
        plaintext = ALL1_64;
        key       = 80'd0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int n = 2; n <= 15; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_busy_pre", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_ct", ciphertext, 64'd0);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 64'(ndone), 64'd0);
        check("abort_ct_idle", ciphertext, 64'd0);
        run_op("post_abort", ALL1_64, 80'd0, CT_F0);

        // Reset has priority over a simultaneous start.
        reset     = 1'b1;
        start     = 1'b1;
        plaintext = 64'd0;
        key       = 80'd0;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check("rst_prio_busy", {63'd0, busy}, 64'd0);
        check("rst_prio_ct", ciphertext, 64'd0);
        @(negedge clk);
        check("rst_prio_busy2", {63'd0, busy}, 64'd0);

        // Start held high: back-to-back operations every 32 cycles.
        plaintext = 64'd0;
        key       = 80'd0;
        start     = 1'b1;
        @(negedge clk);
        plaintext = ALL1_64;
        key       = ALL1_80;
        ndone      = 0;
        ct_changed = 0;
        for (int n = 2; n <= 64; n++) begin
            @(negedge clk);
            if (n == 32) begin
                check("b2b_done_c32", {63'd0, done}, 64'd1);
                check("b2b_ct1", ciphertext, CT_00);
            end else if (n == 33) begin
                check("b2b_busy_c33", {63'd0, busy}, 64'd1);
            end else if (n == 64) begin
                check("b2b_done_c64", {63'd0, done}, 64'd1);
                check("b2b_ct2", ciphertext, CT_FF);
            end else begin
                if (n > 32 && ciphertext !== CT_00) ct_changed++;
            end
            if (done) ndone++;
        end
        start = 1'b0;
        check("b2b_ct1_hold", 64'(ct_changed), 64'd0);
        check("b2b_done_count", 64'(ndone), 64'd2);
        @(negedge clk);
        check("b2b_done_c65", {63'd0, done}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/present_cipher_core.md
PRESENT_CIPHER_CORE -- requirements
Module: present_cipher_core

Interface
REQ-001 The block SHALL have one parameter: ROUNDS, default 31, the number of full PRESENT rounds before final key whitening.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request to encrypt; sampled on the rising edge.
REQ-006 Port plaintext, input, 64 bits: input block; sampled only on an accepted start.
REQ-007 Port key, input, 80 bits: PRESENT-80 key; sampled only on an accepted start.
REQ-008 Port busy, output, 1 bit: high while rounds are in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when ciphertext becomes valid.
REQ-010 Port ciphertext, output, 64 bits: result, held stable from done until the next accepted start.

Function
REQ-011 The FSM SHALL have two states: IDLE and RUN.
REQ-012 In IDLE, start=1 SHALL be accepted: load state=plaintext, key register=key, round counter=1, busy=1, and go to RUN.
REQ-013 A start SHALL also be accepted in the cycle done is high, since the FSM is then in IDLE.
REQ-014 In RUN, start SHALL be ignored, and plaintext/key changes SHALL have no effect.
REQ-015 Each RUN cycle SHALL perform one round: state <= pLayer(sBoxLayer(state XOR key[79:16])).
REQ-016 sBoxLayer SHALL apply the PRESENT S-box to all 16 nibbles: C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
REQ-017 pLayer SHALL move bit i to position (16*i) mod 63 for i=0..62; bit 63 stays at 63.
REQ-018 The key register SHALL update in the same cycle as each round, in three steps:
- rotate left 61;
- pass bits [79:76] through the S-box;
- XOR bits [19:15] with the 5-bit round counter value used in that round.
REQ-019 The round counter SHALL increment by 1 per RUN cycle.
REQ-020 In the RUN cycle with counter=ROUNDS, the block SHALL, at the clock edge:
- register ciphertext = (round result) XOR (updated key[79:16]);
- set done=1, busy=0;
- return to IDLE.
REQ-021 Latency SHALL be fixed at ROUNDS+1 cycles (32 by default): done is high exactly ROUNDS+1 cycles after the edge that accepted start.
REQ-022 done SHALL be high for exactly one cycle per accepted start.
REQ-023 ciphertext SHALL change only at the edge where done rises.
REQ-024 Throughput SHALL be one block per ROUNDS+1 cycles when start is held high continuously.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL:
- go to IDLE;
- set busy=0, done=0, ciphertext=0;
- clear the state, key register and round counter to 0.
REQ-026 A reset mid-RUN SHALL abort the operation with no done pulse.
REQ-027 reset SHALL take priority over a simultaneous start.
REQ-028 The first start SHALL be accepted on the first edge after reset deasserts.

Structure
REQ-029 A shared package present_pkg SHALL hold:
- constants BLOCK_W=64, KEY_W=80, default ROUNDS=31, counter width 5;
- the FSM state enum;
- the pLayer bit-permutation function.
REQ-030 The existing SBox module (ports substituted, orig) SHALL be the only sub-module: 16 instances on the datapath and 1 in the key schedule.
REQ-031 The datapath SHALL be iterative, one round per cycle; no unrolled round pipeline.

Verification
REQ-032 plaintext=0, key=0, start pulse -> done exactly 32 cycles later, ciphertext=5579C1387B228445.
REQ-033 plaintext=0, key=FFFFFFFFFFFFFFFFFFFF -> ciphertext=E72C46C0F5945049.
REQ-034 plaintext=FFFFFFFFFFFFFFFF, key=0 -> ciphertext=A112FFC72F68417B. Then plaintext and key both all-F -> ciphertext=3333DCD3213210D2.
REQ-035 Start pulse plus changed plaintext/key during RUN (cycle 10) -> both ignored; result equals the first request's ciphertext; single done pulse.
REQ-036 reset at cycle 15 of RUN -> busy=0, done never pulses, ciphertext=0. A new start afterwards completes correctly in 32 cycles.
REQ-037 start held high over two operations -> done pulses at cycles 32 and 64. The ciphertext from the first done holds until the second done.
